// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, read-only instruction cache between the fetch
//            unit and pmem. Hits answer one cycle after the request handshake;
//            misses refill the whole line word by word from word 0, then
//            replay the lookup. A flush (fence.i) invalidates every line.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch unit side
  input  logic                  req_valid_ifu_i,
  input  logic [ADDR_WIDTH-1:0] addr_ifu_i,
  output logic                  req_ready_ifu_o,
  output logic                  rsp_valid_ifu_o,
  output logic [DATA_WIDTH-1:0] instr_ifu_o,
  input  logic                  flush_ifu_i,
  // pmem side
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_dat_i
);

  // Address split: {tag, index, word offset, byte offset(2)}
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int WORDS = NUM_LINES * LINE_WORDS;
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_LOOKUP      = 2'd1,
    S_REFILL_REQ  = 2'd2,
    S_REFILL_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request address, byte offset dropped (instructions are word aligned)
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [OFF_W-1:0]      cnt_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [WORDS];

  // Last driven values of the don't-care outputs, so they hold when inactive
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] instr_q;

  // Decoded fields of the latched address
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [OFF_W-1:0]      req_off;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [ADDR_WIDTH-1:0] refill_addr;

  // Control strobes produced by the next-state logic
  logic accept;
  logic flush_all;
  logic cnt_clr;
  logic cnt_inc;
  logic word_we;
  logic line_done;

  // The byte offset of the fetch address carries no information here
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_ifu_i[1:0];

  assign req_tag = addr_q[ADDR_WIDTH-3 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_off = addr_q[0 +: OFF_W];

  assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word    = data_mem[{req_idx, req_off}];
  assign refill_addr = {req_tag, req_idx, cnt_q, 2'b00};

  // Active outputs come straight from the arrays; otherwise replay last value
  assign instr_ifu_o = rsp_valid_ifu_o ? hit_word    : instr_q;
  assign mem_addr_o  = mem_req_valid_o ? refill_addr : mem_addr_q;

  // Next-state and handshake logic; flush is only honoured where ready is
  // gated (IDLE, LOOKUP-hit), never in the middle of a refill
  always_comb begin
    state_d         = state_q;
    req_ready_ifu_o = 1'b0;
    rsp_valid_ifu_o = 1'b0;
    mem_req_valid_o = 1'b0;
    accept          = 1'b0;
    flush_all       = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    word_we         = 1'b0;
    line_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_ifu_o = !flush_ifu_i;
        if (flush_ifu_i) begin
          flush_all = 1'b1;
        end else if (req_valid_ifu_i) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid_ifu_o = 1'b1;
          req_ready_ifu_o = !flush_ifu_i;
          if (req_valid_ifu_i && !flush_ifu_i) begin
            accept = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_clr = 1'b1;
          state_d = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_rsp_valid_i) begin
          word_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            line_done = 1'b1;
            state_d   = S_LOOKUP;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_REFILL_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch, word counter and valid bits (cleared by reset/flush)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= addr_ifu_i[ADDR_WIDTH-1:2];
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + OFF_W'(1);
      end
      if (flush_all) begin
        valid_q <= '0;
      end else if (line_done) begin
        valid_q[req_idx] <= 1'b1;
      end
    end
  end

  // Hold registers for the pmem address and the instruction output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      instr_q    <= '0;
    end else begin
      if (mem_req_valid_o) begin
        mem_addr_q <= refill_addr;
      end
      if (rsp_valid_ifu_o) begin
        instr_q <= hit_word;
      end
    end
  end

  // Tag and data arrays: no reset, only the valid bits qualify their contents
  always_ff @(posedge clk) begin
    if (word_we) begin
      data_mem[{req_idx, cnt_q}] <= mem_dat_i;
    end
    if (line_done) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Randomised self-checking bench for icache. A reference model of
//            the cache contents (valid/tag per index) predicts hit or miss,
//            the refill address sequence, response latency and data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_ifu_i = 1'b0;
  logic [31:0] addr_ifu_i = '0;
  logic        req_ready_ifu_o;
  logic        rsp_valid_ifu_o;
  logic [31:0] instr_ifu_o;
  logic        flush_ifu_i = 1'b0;
  logic        mem_req_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_req_ready_i = 1'b1;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_dat_i = '0;

  icache #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .NUM_LINES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_ifu_i(req_valid_ifu_i), .addr_ifu_i(addr_ifu_i),
    .req_ready_ifu_o(req_ready_ifu_o), .rsp_valid_ifu_o(rsp_valid_ifu_o),
    .instr_ifu_o(instr_ifu_o), .flush_ifu_i(flush_ifu_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_addr_o(mem_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_dat_i(mem_dat_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Backing memory contents: every word distinct and easy to recognise
  function automatic logic [31:0] pmem_word(logic [31:0] a);
    return 32'h1000 + ((a - 32'h8000_0000) >> 2);
  endfunction

  // ---------------- reference model ----------------
  bit          mv [16];
  logic [23:0] mt [16];

  typedef struct {
    logic [31:0] data;
    int          hs_cyc;
    bit          hit;
  } exp_t;

  logic [31:0] iq[$];        // addresses still to be issued
  exp_t        oq[$];        // accepted requests awaiting a response
  logic [31:0] exp_mem_q[$]; // expected refill word addresses, in order

  int ready_mode  = 0;   // 0: always ready, 1: random, 2: stall word 2
  bit spurious_en = 0;
  int stall_left  = 0;
  int extra_lat   = 0;
  int rsp_delivered = 0;
  int first_rsp, last_rsp;

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 0;
  endtask

  task automatic model_accept(logic [31:0] a);
    int          idx;
    logic [23:0] tg;
    bit          h;
    idx = int'((a / 16) % 16);
    tg  = 24'(a / 256);
    h   = mv[idx] && (mt[idx] == tg);
    if (!h) begin
      for (int i = 0; i < 4; i++) exp_mem_q.push_back((a & 32'hFFFF_FFF0) + 32'(4 * i));
      mv[idx] = 1;
      mt[idx] = tg;
    end
    oq.push_back('{pmem_word(a & 32'hFFFF_FFFC), cyc, h});
  endtask

  // ---------------- pmem responder ----------------
  initial begin : pmem
    bit          hs_prev, stalled_prev, r;
    logic [31:0] hs_addr, stall_addr, e;
    hs_prev = 0;
    stalled_prev = 0;
    forever begin
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      mem_dat_i       = '0;
      if (!rst_n) begin
        hs_prev = 0;
        stalled_prev = 0;
        mem_req_ready_i = 1'b1;
      end else begin
        if (stalled_prev) begin
          check("stall_valid", 32'(mem_req_valid_o), 32'd1);
          check("stall_addr", mem_addr_o, stall_addr);
        end
        if (hs_prev) begin
          mem_rsp_valid_i = 1'b1;
          mem_dat_i = pmem_word(hs_addr);
          rsp_delivered++;
        end else if (mem_req_valid_o && spurious_en && ($urandom_range(0, 1) == 1)) begin
          mem_rsp_valid_i = 1'b1;
          mem_dat_i = 32'hDEAD_BEEF;
        end
        case (ready_mode)
          1:       r = ($urandom_range(0, 2) != 0);
          2:       r = !(mem_req_valid_o && (mem_addr_o[3:2] == 2'd2) && (stall_left > 0));
          default: r = 1;
        endcase
        if (!r && mem_req_valid_o && ready_mode == 2) stall_left--;
        mem_req_ready_i = r;
        hs_prev = mem_req_valid_o && r;
        stalled_prev = mem_req_valid_o && !r;
        stall_addr = mem_addr_o;
        if (hs_prev) begin
          hs_addr = mem_addr_o;
          e = (exp_mem_q.size() > 0) ? exp_mem_q.pop_front() : 32'hFFFF_FFFF;
          check("mem_addr", mem_addr_o, e);
        end
      end
    end
  end

  // ---------------- fetch driver ----------------
  task automatic run_queue();
    int   guard, lat;
    exp_t e;
    guard = 0;
    first_rsp = -1;
    last_rsp = -1;
    while ((iq.size() > 0 || oq.size() > 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (rsp_valid_ifu_o) begin
        if (oq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid_ifu_o), 32'd0);
        end else begin
          e = oq.pop_front();
          lat = cyc - e.hs_cyc;
          if (first_rsp < 0) first_rsp = cyc;
          last_rsp = cyc;
          check("instr", instr_ifu_o, e.data);
          if (e.hit)                check("lat_hit", 32'(lat), 32'd1);
          else if (ready_mode == 1) check("lat_miss_min", 32'(lat >= 10), 32'd1);
          else                      check("lat_miss", 32'(lat), 32'(10 + extra_lat));
        end
      end
      if (iq.size() > 0) begin
        req_valid_ifu_i = 1'b1;
        addr_ifu_i = iq[0];
      end else begin
        req_valid_ifu_i = 1'b0;
      end
      #1;
      if (req_valid_ifu_i && req_ready_ifu_o) model_accept(iq.pop_front());
    end
    check("run_timeout", 32'(guard < 3000), 32'd1);
    req_valid_ifu_i = 1'b0;
    check("mem_left", 32'(exp_mem_q.size()), 32'd0);
    iq.delete();
    oq.delete();
  endtask

  task automatic fetch1(logic [31:0] a);
    iq.push_back(a);
    run_queue();
  endtask

  // Flush while idle with a request also pending: the request must be refused
  task automatic do_flush(logic [31:0] a);
    @(negedge clk);
    flush_ifu_i = 1'b1;
    req_valid_ifu_i = 1'b1;
    addr_ifu_i = a;
    #1;
    check("flush_ready", 32'(req_ready_ifu_o), 32'd0);
    @(negedge clk);
    flush_ifu_i = 1'b0;
    req_valid_ifu_i = 1'b0;
    model_clear();
  endtask

  task automatic reset_mid_refill(logic [31:0] a);
    int base, g;
    ready_mode = 0;
    spurious_en = 0;
    base = rsp_delivered;
    @(negedge clk);
    req_valid_ifu_i = 1'b1;
    addr_ifu_i = a;
    #1;
    check("rmr_accept", 32'(req_ready_ifu_o), 32'd1);
    for (int i = 0; i < 4; i++) exp_mem_q.push_back((a & 32'hFFFF_FFF0) + 32'(4 * i));
    @(negedge clk);
    req_valid_ifu_i = 1'b0;
    g = 0;
    while (rsp_delivered < base + 2 && g < 100) begin
      @(negedge clk);
      #2;
      g++;
    end
    check("rmr_wait", 32'(g < 100), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmr_rst_ready", 32'(req_ready_ifu_o), 32'd1);
    check("rmr_rst_rsp", 32'(rsp_valid_ifu_o), 32'd0);
    check("rmr_rst_memv", 32'(mem_req_valid_o), 32'd0);
    check("rmr_rst_addr", mem_addr_o, 32'd0);
    exp_mem_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmr_ready_after", 32'(req_ready_ifu_o), 32'd1);
  endtask

  initial begin : main
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready_ifu_o), 32'd1);
    check("rst_rsp", 32'(rsp_valid_ifu_o), 32'd0);
    check("rst_instr", instr_ifu_o, 32'd0);
    check("rst_memv", 32'(mem_req_valid_o), 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    flush_ifu_i = 1'b1;
    #1;
    check("rst_ready_flush", 32'(req_ready_ifu_o), 32'd0);
    flush_ifu_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // cold miss, then a back-to-back hit stream on the same line
    fetch1(32'h8000_0000);
    iq.push_back(32'h8000_0004);
    iq.push_back(32'h8000_0008);
    iq.push_back(32'h8000_000C);
    run_queue();
    check("stream_span", 32'(last_rsp - first_rsp), 32'd2);

    // conflicting tag on index 0, then back again
    fetch1(32'h8000_0100);
    fetch1(32'h8000_0000);

    // five-cycle stall on word 2 with spurious responses during REFILL_REQ
    ready_mode = 2;
    spurious_en = 1;
    stall_left = 5;
    extra_lat = 5;
    fetch1(32'h8000_0010);
    check("stall_used", 32'(stall_left), 32'd0);
    extra_lat = 0;
    ready_mode = 0;
    spurious_en = 0;
    fetch1(32'h8000_0018);

    // flush with lines valid, then the old line must miss again
    do_flush(32'h8000_0000);
    fetch1(32'h8000_0000);

    // reset in the middle of a refill
    reset_mid_refill(32'h8000_0020);
    fetch1(32'h8000_0020);

    // randomised traffic: bursts, random pmem readiness, occasional flush
    ready_mode = 1;
    spurious_en = 1;
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        iq.push_back(32'h8000_0000 + (32'($urandom_range(0, 255)) << 2));
      run_queue();
      if ($urandom_range(0, 7) == 0) do_flush(32'h8000_0000 + (32'($urandom_range(0, 255)) << 2));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the npc fetch unit and pmem. It accepts fetch requests from the IFU over a valid/ready handshake and returns the 32-bit instruction one cycle after a hit. On a miss it refills the whole line from memory, one word request outstanding at a time, then replays the lookup. A flush request invalidates every line, for fence.i.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, instruction/word width
- LINE_WORDS, 4, words per line (power of 2, ≥2)
- NUM_LINES, 16, number of lines (power of 2)
- Address split, defaults shown: word offset [3:2], index [7:4], tag [31:8]; bits [1:0] ignored.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_ifu_i  in  1  fetch request valid
- addr_ifu_i  in  ADDR_WIDTH  fetch address
- req_ready_ifu_o  out  1  request accepted when valid&ready
- rsp_valid_ifu_o  out  1  instruction valid; one-cycle pulse, no back-pressure
- instr_ifu_o  out  DATA_WIDTH  fetched instruction
- flush_ifu_i  in  1  invalidate all lines (level, held by IFU until honored)
- mem_req_valid_o  out  1  word read request to pmem
- mem_addr_o  out  ADDR_WIDTH  word-aligned read address
- mem_req_ready_i  in  1  pmem accepts request
- mem_rsp_valid_i  in  1  read data valid
- mem_dat_i  in  DATA_WIDTH  read data

## Operation
- Storage per line: valid bit, tag, LINE_WORDS data words. Reset clears all valid bits only.
- States:
  - IDLE: req_ready_ifu_o = !flush_ifu_i. If flush_ifu_i, all valid bits clear at this edge and the state stays IDLE. Otherwise, on a request handshake, latch the address and go to LOOKUP.
  - LOOKUP: compare the latched tag against the indexed line.
    - Hit: rsp_valid_ifu_o=1 and instr_ifu_o=data[index][offset], both combinational from registers. req_ready_ifu_o=1, except 0 if flush_ifu_i is high. A new handshake latches the new address and stays in LOOKUP; otherwise go to IDLE.
    - Miss: rsp_valid_ifu_o=0, req_ready_ifu_o=0. Clear word counter; go to REFILL_REQ.
  - REFILL_REQ: mem_req_valid_o=1, mem_addr_o={tag,index,counter,2'b00}. Hold until mem_req_ready_i, then go to REFILL_WAIT.
  - REFILL_WAIT: on mem_rsp_valid_i, write mem_dat_i to word[counter].
    - Last word: set valid, write tag, go to LOOKUP (guaranteed hit).
    - Otherwise: counter++, go to REFILL_REQ.
- mem_rsp_valid_i is ignored outside REFILL_WAIT. pmem never returns data in the same cycle as the request handshake.
- Refill always starts at word 0. There is no critical-word-first.
- flush_ifu_i is honored only in IDLE, and in LOOKUP via the ready gating. It is never honored mid-refill: the IFU holds it until it takes effect.
- Outputs outside their active states: mem_req_valid_o=0, rsp_valid_ifu_o=0. mem_addr_o and instr_ifu_o are don't-care but hold their last value.

## Timing
- Reset values, asynchronous: state IDLE; all valid bits 0; counter 0; mem_req_valid_o=0; mem_addr_o=0; rsp_valid_ifu_o=0; instr_ifu_o=0; req_ready_ifu_o=1 (combinational, 0 if flush_ifu_i).
- Hit latency: request accepted at edge T, response in cycle T+1.
- Back-to-back hits: one per cycle.
- Miss latency with pmem ready=1 and 1-cycle response: request at T; LOOKUP miss at T+1; REFILL_REQ at T+2/4/6/8; data at T+3/5/7/9; hit response at T+10.
- Reset asserted mid-refill: the refill is abandoned and no line is marked valid. pmem must tolerate the orphaned request.
- Index aliasing: a refill overwrites the previous line with the same index unconditionally.

## Test plan
- Cold miss: reset, fetch 0x8000_0000 with pmem returning 0x1000+i per word. Expect 4 mem requests at 0x8000_0000/4/8/C and rsp_valid at T+10 with instr 0x1000.
- Hit stream: after the cold miss, fetch 0x8000_0004, _0008 and _000C back-to-back. Expect rsp_valid on 3 consecutive cycles with 0x1001, 0x1002, 0x1003, and no mem requests.
- Conflict: fetch 0x8000_0100 (same index 0, new tag). Expect a refill. Then refetch 0x8000_0000 and expect a second refill.
- Stalled memory: hold mem_req_ready_i=0 for 5 cycles on word 2. Expect mem_req_valid_o and mem_addr_o stable throughout, and that spurious mem_rsp_valid_i in REFILL_REQ is ignored.
- Flush: with lines valid, assert flush_ifu_i in IDLE for 1 cycle with req_valid high. Expect req_ready 0 in that cycle, then the next fetch of 0x8000_0000 misses.
- Reset mid-refill: drop rst_n after word 1 returns. After release expect req_ready=1, no valid lines, and a fetch of the same address misses.
